// File: rtl/lsu.sv
// lsu: memory-stage load/store unit; issues one valid/ready memory transaction per op and returns extended load data.
module lsu #(
  parameter int W_SIZE = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              is_load,
  input  logic              is_store,
  input  logic [2:0]        funct3,
  input  logic [W_SIZE-1:0] addr,
  input  logic [W_SIZE-1:0] store_data,
  input  logic [4:0]        rd_in,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [W_SIZE-1:0] mem_addr,
  output logic [3:0]        mem_we,
  output logic [W_SIZE-1:0] mem_wdata,
  input  logic              mem_rvalid,
  input  logic [W_SIZE-1:0] mem_rdata,
  output logic              resp_valid,
  output logic              resp_wb,
  output logic [W_SIZE-1:0] resp_data,
  output logic [4:0]        resp_rd,
  output logic              fault
);
  localparam logic [1:0] IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2, RESP = 2'd3;
  logic [1:0] state;
  logic ld;
  logic [2:0] f3;
  logic [1:0] off;
  logic [4:0] rd;
  logic bad_f3, misaligned, bad;
  logic [3:0] we_n;
  logic [W_SIZE-1:0] wdata_n, sh, ext;
  assign req_ready = (state == IDLE);
  always_comb begin
    bad_f3 = (funct3[1:0] == 2'b11) || (funct3[2] && (is_store || funct3[1]));
    misaligned = (funct3[1:0] == 2'b01 && addr[0]) || (funct3[1:0] == 2'b10 && addr[1:0] != 2'b00);
    bad = (is_load == is_store) || bad_f3 || misaligned;
    we_n = funct3[1:0] == 2'b00 ? 4'b0001 << addr[1:0] :
           funct3[1:0] == 2'b01 ? 4'b0011 << addr[1:0] : 4'b1111;
    wdata_n = funct3[1:0] == 2'b00 ? {4{store_data[7:0]}} :
              funct3[1:0] == 2'b01 ? {2{store_data[15:0]}} : store_data;
  end
  // Lane-shift the returned word, then sign-extend unless the access is unsigned (funct3[2]).
  always_comb begin
    sh = mem_rdata >> {off, 3'b000};
    ext = f3[1:0] == 2'b10 ? mem_rdata :
          f3[1:0] == 2'b01 ? {{16{~f3[2] & sh[15]}}, sh[15:0]} :
                             {{24{~f3[2] & sh[7]}}, sh[7:0]};
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      ld            <= 1'b0;
      f3            <= 3'b000;
      off           <= 2'b00;
      rd            <= 5'd0;
      mem_req_valid <= 1'b0;
      mem_addr      <= '0;
      mem_we        <= 4'b0000;
      mem_wdata     <= '0;
      resp_valid    <= 1'b0;
      resp_wb       <= 1'b0;
      resp_data     <= '0;
      resp_rd       <= 5'd0;
      fault         <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      resp_wb    <= 1'b0;
      resp_data  <= '0;
      resp_rd    <= 5'd0;
      fault      <= 1'b0;
      case (state)
        IDLE: if (req_valid) begin
          ld  <= is_load;
          f3  <= funct3;
          off <= addr[1:0];
          rd  <= rd_in;
          if (bad) begin
            state      <= RESP;
            resp_valid <= 1'b1;
            fault      <= 1'b1;
            resp_rd    <= rd_in;
          end else begin
            state         <= REQ;
            mem_req_valid <= 1'b1;
            mem_addr      <= {addr[W_SIZE-1:2], 2'b00};
            mem_we        <= is_load ? 4'b0000 : we_n;
            mem_wdata     <= is_load ? '0 : wdata_n;
          end
        end
        REQ: if (mem_req_ready) begin
          mem_req_valid <= 1'b0;
          state         <= ld ? WAIT : RESP;
          resp_valid    <= ~ld;
          resp_rd       <= ld ? 5'd0 : rd;
        end
        WAIT: if (mem_rvalid) begin
          state      <= RESP;
          resp_valid <= 1'b1;
          resp_wb    <= 1'b1;
          resp_data  <= ext;
          resp_rd    <= rd;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lsu.sv
// tb_lsu: directed bench for lsu; a transaction-level model sets per-cycle expectations checked on every falling edge.
module tb_lsu;
  logic clk = 1'b0, rst_n = 1'b0;
  logic req_valid = 1'b0, is_load = 1'b0, is_store = 1'b0;
  logic [2:0] funct3 = 3'b000;
  logic [31:0] addr = '0, store_data = '0, mem_rdata = '0;
  logic [4:0] rd_in = '0;
  logic mem_req_ready = 1'b0, mem_rvalid = 1'b0;
  logic req_ready, mem_req_valid, resp_valid, resp_wb, fault;
  logic [31:0] mem_addr, mem_wdata, resp_data;
  logic [3:0] mem_we;
  logic [4:0] resp_rd;
  int vectors = 0, miscompares = 0;
  bit chk_en = 1'b0;
  logic exp_rr, exp_mv, exp_wchk, exp_rv, exp_wb, exp_flt;
  logic [31:0] exp_ma, exp_wd, exp_rdat;
  logic [3:0] exp_we;
  logic [4:0] exp_rd;

  lsu #(.W_SIZE(32)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .is_load(is_load), .is_store(is_store), .funct3(funct3), .addr(addr),
    .store_data(store_data), .rd_in(rd_in), .mem_req_valid(mem_req_valid),
    .mem_req_ready(mem_req_ready), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .resp_valid(resp_valid), .resp_wb(resp_wb), .resp_data(resp_data),
    .resp_rd(resp_rd), .fault(fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got 0x%08h expected 0x%08h", n, $time, act, exp);
    end
  endtask

  // Access rules expressed as byte sizes, alignment by modulo and lane replication by index.
  function automatic void model(input logic ld, input logic st, input logic [2:0] f3,
                                input logic [31:0] a, input logic [31:0] d, input logic [31:0] rw,
                                output logic flt, output logic [3:0] we, output logic [31:0] wd,
                                output logic [31:0] rdat);
    int sz, o;
    logic [31:0] sh;
    sz = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    o = int'(a[1:0]);
    flt = (ld == st) || (f3[1:0] == 2'b11) || (st && f3[2]) || (ld && f3 == 3'b110) || (o % sz != 0);
    we = '0;
    wd = '0;
    for (int i = 0; i < 4; i++) begin
      wd[8*i +: 8] = d[8*(i % sz) +: 8];
      if (i >= o && i < o + sz) we[i] = 1'b1;
    end
    sh = rw >> (8 * o);
    if (sz == 4) rdat = rw;
    else if (sz == 2) rdat = f3[2] ? {16'h0, sh[15:0]} : 32'($signed(sh[15:0]));
    else rdat = f3[2] ? {24'h0, sh[7:0]} : 32'($signed(sh[7:0]));
  endfunction

  task automatic idle_exp();
    exp_rr = 1'b1; exp_mv = 1'b0; exp_wchk = 1'b0; exp_rv = 1'b0;
    exp_wb = 1'b0; exp_rdat = '0; exp_rd = '0; exp_flt = 1'b0;
  endtask

  always @(negedge clk) if (chk_en) begin
    chk("req_ready", 32'(req_ready), 32'(exp_rr));
    chk("mem_req_valid", 32'(mem_req_valid), 32'(exp_mv));
    if (exp_mv) begin
      chk("mem_addr", mem_addr, exp_ma);
      chk("mem_we", 32'(mem_we), 32'(exp_we));
    end
    if (exp_mv && exp_wchk) chk("mem_wdata", mem_wdata, exp_wd);
    chk("resp_valid", 32'(resp_valid), 32'(exp_rv));
    chk("resp_wb", 32'(resp_wb), 32'(exp_wb));
    chk("resp_data", resp_data, exp_rdat);
    chk("resp_rd", 32'(resp_rd), 32'(exp_rd));
    chk("fault", 32'(fault), 32'(exp_flt));
  end

  // One operation; called right after a rising edge, returns right after a rising edge with the LSU idle.
  task automatic run(input logic ld, input logic st, input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] d, input logic [4:0] rd, input logic [31:0] rw,
                     input int rdy_dly, input int rv_dly, input bit stray, input bit hold);
    logic flt;
    logic [3:0] we;
    logic [31:0] wd, rdat;
    model(ld, st, f3, a, d, rw, flt, we, wd, rdat);
    req_valid = 1'b1; is_load = ld; is_store = st; funct3 = f3;
    addr = a; store_data = d; rd_in = rd;
    if (stray) begin mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF; end
    @(posedge clk) #1;
    req_valid = hold;
    exp_rr = 1'b0;
    if (flt) begin
      mem_rvalid = 1'b0;
      exp_rv = 1'b1; exp_flt = 1'b1; exp_rd = rd;
      @(posedge clk) #1;
    end else begin
      exp_mv = 1'b1; exp_ma = {a[31:2], 2'b00}; exp_we = ld ? 4'b0000 : we;
      exp_wd = wd; exp_wchk = st;
      for (int i = 0; i < rdy_dly; i++) @(posedge clk) #1;
      mem_req_ready = 1'b1;
      @(posedge clk) #1;
      mem_req_ready = 1'b0; mem_rvalid = 1'b0; exp_mv = 1'b0;
      if (st) begin
        exp_rv = 1'b1; exp_rd = rd;
      end else begin
        for (int i = 0; i < rv_dly; i++) @(posedge clk) #1;
        mem_rvalid = 1'b1; mem_rdata = rw;
        @(posedge clk) #1;
        mem_rvalid = 1'b0;
        exp_rv = 1'b1; exp_wb = 1'b1; exp_rdat = rdat; exp_rd = rd;
      end
      @(posedge clk) #1;
    end
    idle_exp();
  endtask

  initial begin
    logic flt;
    logic [3:0] we;
    logic [31:0] wd, rdat;
    model(1, 0, 3'b000, 32'h2002, 0, 32'h12F0_3456, flt, we, wd, rdat);
    chk("model_lb", rdat, 32'hFFFF_FFF0);
    model(1, 0, 3'b100, 32'h2002, 0, 32'h12F0_3456, flt, we, wd, rdat);
    chk("model_lbu", rdat, 32'h0000_00F0);
    model(1, 0, 3'b001, 32'h2002, 0, 32'h8001_0000, flt, we, wd, rdat);
    chk("model_lh", rdat, 32'hFFFF_8001);
    model(1, 0, 3'b101, 32'h2000, 0, 32'h0000_8001, flt, we, wd, rdat);
    chk("model_lhu", rdat, 32'h0000_8001);
    model(0, 1, 3'b000, 32'h1003, 32'hAABB_CC5A, 0, flt, we, wd, rdat);
    chk("model_sb_we", 32'(we), 32'h8);
    chk("model_sb_wd", wd, 32'h5A5A_5A5A);
    model(1, 0, 3'b010, 32'h3001, 0, 0, flt, we, wd, rdat);
    chk("model_lw_flt", 32'(flt), 32'h1);

    #2;
    chk("rst_req_ready", 32'(req_ready), 32'h1);
    chk("rst_mem_req_valid", 32'(mem_req_valid), 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_we", 32'(mem_we), 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_resp", {resp_data[27:0], resp_rd[0], resp_valid, resp_wb, fault}, 32'h0);
    @(posedge clk) #1;
    rst_n = 1'b1;
    idle_exp();
    chk_en = 1'b1;
    @(posedge clk) #1;

    run(0, 1, 3'b000, 32'h1003, 32'hAABB_CC5A, 5'd3, 0, 3, 0, 0, 0);
    run(1, 0, 3'b000, 32'h2002, 0, 5'd5, 32'h12F0_3456, 0, 0, 0, 0);
    run(1, 0, 3'b100, 32'h2002, 0, 5'd6, 32'h12F0_3456, 0, 0, 0, 0);
    run(1, 0, 3'b001, 32'h2002, 0, 5'd7, 32'h8001_0000, 1, 0, 0, 0);
    run(1, 0, 3'b101, 32'h2000, 0, 5'd8, 32'h0000_8001, 0, 1, 0, 0);
    run(1, 0, 3'b010, 32'h2000, 0, 5'd9, 32'hCAFE_F00D, 0, 2, 0, 0);
    run(1, 0, 3'b000, 32'h2001, 0, 5'd10, 32'h0000_7F00, 0, 0, 0, 0);
    run(0, 1, 3'b001, 32'h1002, 32'h1234_ABCD, 5'd11, 0, 0, 0, 0, 0);
    run(0, 1, 3'b000, 32'h1001, 32'h0000_0081, 5'd12, 0, 0, 0, 0, 0);
    run(1, 0, 3'b010, 32'h3001, 0, 5'd13, 0, 0, 0, 0, 0);
    run(0, 1, 3'b001, 32'h3003, 32'h5555, 5'd14, 0, 0, 0, 0, 0);
    run(1, 0, 3'b011, 32'h3000, 0, 5'd15, 0, 0, 0, 0, 0);
    run(0, 0, 3'b010, 32'h3000, 0, 5'd16, 0, 0, 0, 0, 0);
    run(1, 1, 3'b010, 32'h3000, 0, 5'd17, 0, 0, 0, 0, 0);
    run(0, 1, 3'b100, 32'h3000, 0, 5'd18, 0, 0, 0, 0, 0);
    run(1, 0, 3'b110, 32'h3000, 0, 5'd19, 0, 0, 0, 0, 0);
    run(0, 1, 3'b010, 32'h4000, 32'h0BAD_F00D, 5'd20, 0, 0, 0, 1, 1);
    run(1, 0, 3'b010, 32'h4000, 0, 5'd21, 32'h7654_3210, 1, 1, 1, 0);
    repeat (2) @(posedge clk) #1;

    // Abort a stalled request with an asynchronous reset between clock edges.
    req_valid = 1'b1; is_load = 1'b0; is_store = 1'b1; funct3 = 3'b000;
    addr = 32'h1003; store_data = 32'hAABB_CC5A; rd_in = 5'd22;
    @(posedge clk) #1;
    req_valid = 1'b0;
    exp_rr = 1'b0; exp_mv = 1'b1; exp_ma = 32'h1000; exp_we = 4'b1000;
    exp_wd = 32'h5A5A_5A5A; exp_wchk = 1'b1;
    @(posedge clk) #1;
    chk_en = 1'b0;
    @(negedge clk) #2;
    rst_n = 1'b0;
    #1;
    chk("arst_mem_req_valid", 32'(mem_req_valid), 32'h0);
    chk("arst_req_ready", 32'(req_ready), 32'h1);
    chk("arst_resp", {resp_data[27:0], resp_rd[0], resp_valid, resp_wb, fault}, 32'h0);
    @(posedge clk) #1;
    rst_n = 1'b1;
    mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    idle_exp();
    chk_en = 1'b1;
    @(posedge clk) #1;
    mem_rvalid = 1'b0;
    repeat (3) @(posedge clk) #1;
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
